// File: rtl/spectrum_pkg.sv
// spectrum_pkg: shared widths, FSM states and averaging constants for the spectrum stages
package spectrum_pkg;
  localparam int LOG_MAG_W = 8;
  localparam int AVG_SHIFT = 2;
  typedef enum logic {SCAN, CLOSE} state_t;
endpackage

// File: rtl/spectrum_avg_ram.sv
// spectrum_avg_ram: per-bin average store, one write and one synchronous read port with write-to-read bypass
module spectrum_avg_ram import spectrum_pkg::*; #(
  parameter int DEPTH = 512,
  parameter int AW = 9
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [LOG_MAG_W-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [LOG_MAG_W-1:0] rdata
);
  logic [LOG_MAG_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end
endmodule

// File: rtl/spectrum_peak_detect.sv
// spectrum_peak_detect: per-frame strongest-bin search with held valid/ready result.
// Define SPECTRUM_PEAK_AVG_EN to smooth each bin with an exponential average before the search.
module spectrum_peak_detect import spectrum_pkg::*; #(
  parameter int N_BINS = 512,
  parameter int BIN_W = 9,
  parameter logic [LOG_MAG_W-1:0] MIN_MAG = 8'd16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  input  logic [LOG_MAG_W-1:0] in_log_mag,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIN_W-1:0]     peak_bin,
  output logic [LOG_MAG_W-1:0] peak_mag,
  output logic                 peak_found,
  output logic                 len_err,
  output logic                 overrun,
  input  logic                 err_clr
);
  state_t state;
  logic [BIN_W-1:0] bin_cnt, max_bin, s_bin;
  logic [LOG_MAG_W-1:0] max_mag, s_mag;
  logic last_bin, beat_end, beat_err, s_valid, s_end;

  assign last_bin = bin_cnt == BIN_W'(N_BINS - 1);
  assign beat_end = in_valid && (in_last || last_bin);
  // an early in_last or a missing one at the final bin are both length errors
  assign beat_err = in_valid && (in_last ^ last_bin);

`ifdef SPECTRUM_PEAK_AVG_EN
  logic [LOG_MAG_W-1:0] mag_q, old_mag, avg, step;
  logic [BIN_W-1:0] bin_q;
  logic v_q, end_q, first_q, first_frame;
  logic signed [LOG_MAG_W:0] diff;

  spectrum_avg_ram #(.DEPTH(N_BINS), .AW(BIN_W)) u_ram (
    .clk(clk), .we(v_q), .waddr(bin_q), .wdata(avg), .raddr(bin_cnt), .rdata(old_mag)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v_q <= 1'b0;
      end_q <= 1'b0;
      mag_q <= '0;
      bin_q <= '0;
      first_q <= 1'b0;
      first_frame <= 1'b1;
    end else begin
      v_q <= in_valid;
      end_q <= beat_end;
      mag_q <= in_log_mag;
      bin_q <= bin_cnt;
      first_q <= first_frame;
      if (beat_end) first_frame <= 1'b0;
    end
  end

  always_comb begin
    diff = $signed({1'b0, mag_q}) - $signed({1'b0, old_mag});
    step = LOG_MAG_W'(diff >>> AVG_SHIFT);
    avg = first_q ? mag_q : old_mag + step;
    s_valid = v_q;
    s_mag = avg;
    s_bin = bin_q;
    s_end = end_q;
  end
`else
  always_comb begin
    s_valid = in_valid;
    s_mag = in_log_mag;
    s_bin = bin_cnt;
    s_end = beat_end;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= SCAN;
      bin_cnt <= '0;
      max_mag <= '0;
      max_bin <= '0;
      out_valid <= 1'b0;
      peak_bin <= '0;
      peak_mag <= '0;
      peak_found <= 1'b0;
      len_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (in_valid) bin_cnt <= beat_end ? '0 : bin_cnt + BIN_W'(1);
      // bin 0 always loads, so the new frame can start while CLOSE reads the old maximum
      if (s_valid && (s_bin == '0 || s_mag > max_mag)) begin
        max_mag <= s_mag;
        max_bin <= s_bin;
      end
      state <= (s_valid && s_end) ? CLOSE : SCAN;
      if (state == CLOSE) begin
        peak_bin <= max_bin;
        peak_mag <= max_mag;
        peak_found <= max_mag >= MIN_MAG;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      len_err <= beat_err || (len_err && !err_clr);
      overrun <= (state == CLOSE && out_valid && !out_ready) || (overrun && !err_clr);
    end
  end
endmodule

// File: tb/tb_spectrum_peak_detect.sv
// tb_spectrum_peak_detect: randomized frames checked against a frame-level argmax reference model
module tb_spectrum_peak_detect;
  localparam int N = 512;
`ifdef SPECTRUM_PEAK_AVG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  typedef struct packed {logic [8:0] bin; logic [7:0] mag; logic found;} res_t;

  logic clk = 0, resetn = 0, in_valid = 0, in_last = 0, out_ready = 1, err_clr = 0;
  logic [7:0] in_log_mag = 0;
  logic out_valid, peak_found, len_err, overrun;
  logic [8:0] peak_bin;
  logic [7:0] peak_mag;
  res_t exp_q[$], got_q[$];
  int frame[$];
  bit first_frame = 1;
`ifdef SPECTRUM_PEAK_AVG_EN
  int avg_mem[N];
`endif
  int checks = 0, passed = 0;

  spectrum_peak_detect #(.N_BINS(N), .BIN_W(9), .MIN_MAG(8'd16)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_log_mag(in_log_mag), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .peak_bin(peak_bin), .peak_mag(peak_mag),
    .peak_found(peak_found), .len_err(len_err), .overrun(overrun), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (resetn && out_valid && out_ready) got_q.push_back({peak_bin, peak_mag, peak_found});

  function automatic void model_reset();
    frame.delete();
    first_frame = 1;
  endfunction

  // A frame is the beats up to in_last or N beats; its peak is the first index of the maximum.
  function automatic void model_beat(int mag, bit last);
    int v, idx, best;
    idx = frame.size();
    v = mag;
`ifdef SPECTRUM_PEAK_AVG_EN
    if (!first_frame) v = (avg_mem[idx] + ((mag - avg_mem[idx]) >>> 2)) & 255;
    avg_mem[idx] = v;
`endif
    frame.push_back(v);
    if (last || frame.size() == N) begin
      best = 0;
      foreach (frame[i]) if (frame[i] > frame[best]) best = i;
      exp_q.push_back({9'(best), 8'(frame[best]), frame[best] >= 16});
      frame.delete();
      first_frame = 0;
    end
  endfunction

  task automatic beat(int mag, bit last);
    @(posedge clk); #1;
    in_valid = 1; in_log_mag = 8'(mag); in_last = last;
    model_beat(mag, last);
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; in_valid = 0; in_last = 0; end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; in_valid = 0; in_last = 0; err_clr = 1;
    @(posedge clk); #1; err_clr = 0;
  endtask

  task automatic wait_results(int n);
    for (int t = 0; t < 3000 && got_q.size() < n; t++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; resetn = 0; in_valid = 0; in_last = 0;
    model_reset();
    @(posedge clk); #1; resetn = 1;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid, peak_bin, peak_mag, peak_found, len_err, overrun} === '0) passed++;
    else $display("FAIL reset: got valid=%b bin=%0d mag=%0d found=%b len_err=%b overrun=%b, want all 0",
                  out_valid, peak_bin, peak_mag, peak_found, len_err, overrun);
  endtask

  task automatic test_single_peak();
    int lat;
    out_ready = 0;
    for (int b = 0; b < N; b++) beat(b == 100 ? 200 : 5, b == N - 1);
    @(posedge clk); #1; in_valid = 0; in_last = 0; lat = 1;
    while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat == LAT) passed++; else $display("FAIL latency: got %0d edges, want %0d", lat, LAT);
    checks++;
    if ({peak_bin, peak_mag, peak_found, len_err} === {9'd100, 8'd200, 1'b1, 1'b0}) passed++;
    else $display("FAIL single_peak: got bin=%0d mag=%0d found=%b len_err=%b, want 100/200/1/0",
                  peak_bin, peak_mag, peak_found, len_err);
    idle(4);
    checks++;
    if ({out_valid, peak_bin, peak_mag, peak_found} === {1'b1, 9'd100, 8'd200, 1'b1}) passed++;
    else $display("FAIL hold: got valid=%b bin=%0d mag=%0d, want 1/100/200", out_valid, peak_bin, peak_mag);
    @(posedge clk); #1; out_ready = 1;
    @(posedge clk); #1;
    checks++;
    if (out_valid === 1'b0) passed++; else $display("FAIL accept: got out_valid=%b, want 0", out_valid);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_tie_threshold();
    res_t g;
    out_ready = 1;
    for (int b = 0; b < N; b++) beat((b == 7 || b == 300) ? 90 : 0, b == N - 1);
    for (int b = 0; b < N; b++) beat(10, b == N - 1);
    idle(1);
    wait_results(exp_q.size());
    checks++;
    if (got_q.size() == exp_q.size()) passed++;
    else $display("FAIL tie count: got %0d results, want %0d", got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < got_q.size()) g = got_q[i]; else g = 'x;
      checks++;
      if (g === exp_q[i]) passed++;
      else $display("FAIL tie[%0d]: got bin=%0d mag=%0d found=%b, want bin=%0d mag=%0d found=%b",
                    i, g.bin, g.mag, g.found, exp_q[i].bin, exp_q[i].mag, exp_q[i].found);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_len_short();
    res_t g;
    out_ready = 1;
    for (int b = 0; b < 256; b++) beat($urandom_range(0, 255), b == 255);
    idle(1);
    wait_results(1);
    g = got_q.size() > 0 ? got_q[0] : 'x;
    checks++;
    if (g === exp_q[0]) passed++;
    else $display("FAIL len_short: got bin=%0d mag=%0d found=%b, want bin=%0d mag=%0d found=%b",
                  g.bin, g.mag, g.found, exp_q[0].bin, exp_q[0].mag, exp_q[0].found);
    checks++;
    if (len_err === 1'b1) passed++; else $display("FAIL len_short flag: got len_err=%b, want 1", len_err);
    pulse_clr();
    checks++;
    if (len_err === 1'b0) passed++; else $display("FAIL len_clr: got len_err=%b, want 0", len_err);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_forced();
    res_t g;
    out_ready = 1;
    for (int b = 0; b <= 600; b++)
      beat(b == 40 ? 220 : b == 530 ? 240 : int'($urandom_range(0, 150)), b == 600);
    idle(1);
    wait_results(2);
    checks++;
    if (got_q.size() == 2 && exp_q.size() == 2) passed++;
    else $display("FAIL forced count: got %0d results, want 2 (model %0d)", got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < got_q.size()) g = got_q[i]; else g = 'x;
      checks++;
      if (g === exp_q[i]) passed++;
      else $display("FAIL forced[%0d]: got bin=%0d mag=%0d found=%b, want bin=%0d mag=%0d found=%b",
                    i, g.bin, g.mag, g.found, exp_q[i].bin, exp_q[i].mag, exp_q[i].found);
    end
    checks++;
    if (len_err === 1'b1) passed++; else $display("FAIL forced flag: got len_err=%b, want 1", len_err);
    pulse_clr();
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    res_t g;
    out_ready = 1;
    for (int k = 0; k < 6; k++) beat($urandom_range(0, 255), 1);
    idle(1);
    wait_results(6);
    checks++;
    if (got_q.size() == exp_q.size()) passed++;
    else $display("FAIL b2b count: got %0d results, want %0d", got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < got_q.size()) g = got_q[i]; else g = 'x;
      checks++;
      if (g === exp_q[i]) passed++;
      else $display("FAIL b2b[%0d]: got bin=%0d mag=%0d found=%b, want bin=%0d mag=%0d found=%b",
                    i, g.bin, g.mag, g.found, exp_q[i].bin, exp_q[i].mag, exp_q[i].found);
    end
    checks++;
    if ({overrun, len_err} === 2'b01) passed++;
    else $display("FAIL b2b flags: got overrun=%b len_err=%b, want 0/1", overrun, len_err);
    pulse_clr();
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < N; b++) beat($urandom_range(0, 255), b == N - 1);
    idle(LAT + 3);
    checks++;
    if ({out_valid, overrun} === 2'b11) passed++;
    else $display("FAIL backpressure flags: got out_valid=%b overrun=%b, want 1/1", out_valid, overrun);
    checks++;
    if ({peak_bin, peak_mag, peak_found} === exp_q[1]) passed++;
    else $display("FAIL backpressure: got bin=%0d mag=%0d found=%b, want bin=%0d mag=%0d found=%b",
                  peak_bin, peak_mag, peak_found, exp_q[1].bin, exp_q[1].mag, exp_q[1].found);
    pulse_clr();
    checks++;
    if ({overrun, len_err, out_valid} === 3'b001) passed++;
    else $display("FAIL err_clr: got overrun=%b len_err=%b out_valid=%b, want 0/0/1", overrun, len_err, out_valid);
    out_ready = 1;
    idle(2);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_mid_reset();
    res_t g;
    out_ready = 0;
    for (int b = 0; b < 10; b++) beat(b == 3 ? 100 : int'($urandom_range(0, 50)), b == 9);
    for (int b = 0; b < 200; b++) beat($urandom_range(0, 255), 0);
    @(posedge clk); #1; resetn = 0; in_valid = 0; in_last = 0;
    #1;
    checks++;
    if ({out_valid, peak_bin, peak_mag, peak_found, len_err, overrun} === '0) passed++;
    else $display("FAIL async_reset: got valid=%b bin=%0d mag=%0d found=%b len_err=%b overrun=%b, want all 0",
                  out_valid, peak_bin, peak_mag, peak_found, len_err, overrun);
    model_reset();
    got_q.delete(); exp_q.delete();
    @(posedge clk); #1; resetn = 1; out_ready = 1;
    for (int b = 0; b < N; b++) beat($urandom_range(0, 255), b == N - 1);
    idle(1);
    wait_results(1);
    g = got_q.size() > 0 ? got_q[0] : 'x;
    checks++;
    if (g === exp_q[0]) passed++;
    else $display("FAIL post_reset: got bin=%0d mag=%0d found=%b, want bin=%0d mag=%0d found=%b",
                  g.bin, g.mag, g.found, exp_q[0].bin, exp_q[0].mag, exp_q[0].found);
    checks++;
    if (len_err === 1'b0) passed++; else $display("FAIL post_reset len_err: got %b, want 0", len_err);
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    res_t g;
    int len;
    out_ready = 1;
    for (int f = 0; f < 4; f++) begin
      len = $urandom_range(1, N);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 7) == 0) idle(1);
        beat($urandom_range(0, 255), b == len - 1);
      end
    end
    idle(1);
    wait_results(exp_q.size());
    checks++;
    if (got_q.size() == exp_q.size()) passed++;
    else $display("FAIL random count: got %0d results, want %0d", got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < got_q.size()) g = got_q[i]; else g = 'x;
      checks++;
      if (g === exp_q[i]) passed++;
      else $display("FAIL random[%0d]: got bin=%0d mag=%0d found=%b, want bin=%0d mag=%0d found=%b",
                    i, g.bin, g.mag, g.found, exp_q[i].bin, exp_q[i].mag, exp_q[i].found);
    end
    pulse_clr();
    got_q.delete(); exp_q.delete();
  endtask

`ifdef SPECTRUM_PEAK_AVG_EN
  task automatic test_averaging();
    do_reset();
    out_ready = 1;
    for (int b = 0; b < N; b++) beat(b == 50 ? 200 : 0, b == N - 1);
    for (int b = 0; b < N; b++) beat(b == 60 ? 100 : 0, b == N - 1);
    idle(1);
    wait_results(2);
    checks++;
    if (got_q.size() == 2 && got_q[0] === {9'd50, 8'd200, 1'b1}) passed++;
    else $display("FAIL avg frame1: got %0d results, want bin 50 mag 200", got_q.size());
    checks++;
    if (got_q.size() == 2 && got_q[1] === {9'd50, 8'd150, 1'b1}) passed++;
    else $display("FAIL avg frame2: got %0d results, want bin 50 mag 150", got_q.size());
    got_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    #1; resetn = 1;
    test_reset();
    test_single_peak();
    test_tie_threshold();
    test_len_short();
    test_forced();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    test_random();
`ifdef SPECTRUM_PEAK_AVG_EN
    test_averaging();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/spectrum_peak_detect.md
# spectrum_peak_detect

Downstream consumer of the log-magnitude stage. Takes the per-bin 8-bit log-magnitude stream of one FFT frame, tracks the strongest bin, and presents a per-frame result (bin index, magnitude, found flag) on a valid/ready output held until consumed. Frame boundaries come from an upstream `in_last` marker, with a bin-count guard. An optional per-bin exponential average smooths the spectrum before the peak search.

## Interface
- `N_BINS`, 512: bins per frame; power of two, at least 4.
- `BIN_W`, 9: bin index width, equal to log2(`N_BINS`).
- `MIN_MAG`, 8'd16: a frame peak below this value is reported as not found.
- `clk` in 1: single clock.
- `resetn` in 1: **reset is asynchronous and active-low.**
- `in_valid` in 1: a bin beat is present (gated by the same enable that advances the log-magnitude pipeline).
- `in_log_mag` in 8: log-magnitude of the current bin, unsigned.
- `in_last` in 1: the current beat is the final bin of its frame.
- `out_valid` out 1: a frame result is held on the outputs.
- `out_ready` in 1: consumer accepts the result.
- `peak_bin` out `BIN_W`: index of the strongest bin.
- `peak_mag` out 8: magnitude of that bin (post-average when averaging is enabled).
- `peak_found` out 1: high when `peak_mag` is at least `MIN_MAG`.
- `len_err` out 1: sticky; the frame length did not equal `N_BINS`.
- `overrun` out 1: sticky; an unconsumed result was overwritten.
- `err_clr` in 1: synchronous clear of both sticky flags.

## Operation
- **States:**
  - SCAN: accumulating the current frame.
  - CLOSE: latching the result, one cycle.
- **Bin counter:** `bin_cnt` counts accepted beats from 0. It is the bin index of the current beat.
- **Running maximum:** `max_mag` and `max_bin`. On each beat the maximum updates only if the beat value is strictly greater than `max_mag`, so ties keep the lowest bin. The first beat of a frame always loads.
- **Normal frame end:** a beat with `in_last=1` ends the frame.
  - If `bin_cnt` is not `N_BINS-1`, set `len_err`.
- **Forced frame end:** a beat at `bin_cnt = N_BINS-1` with `in_last=0` also ends the frame.
  - Set `len_err`.
  - The next beat starts a new frame at bin 0. There is no wrap into the old frame.
- **CLOSE:** the result registers load from the running maximum, and `out_valid` goes to 1. The counter and maximum reset for the next frame. Beats arriving during CLOSE are accepted into the new frame (the counter is already 0), so no beats are lost.
- **Overwrite:** if `out_valid=1` and `out_ready=0` when a new result loads, the new result replaces the old one and `overrun` is set.
- **Simultaneous events:**
  - A load and an `out_ready` acceptance in the same cycle: the load wins, `out_valid` stays 1, and `overrun` is not set.
  - `err_clr` and a new error event in the same cycle: the set wins.
- **Arithmetic:** all compares are unsigned, 8-bit. No saturation is needed.

## Timing
- **Reset values:**
  - `out_valid=0`, `peak_bin=0`, `peak_mag=0`, `peak_found=0`, `len_err=0`, `overrun=0`.
  - State is SCAN, counter 0.
- **Reset mid-frame:** the partial frame is discarded. The next beat is bin 0.
- **Latency without averaging:** `out_valid` rises on the 2nd rising edge after the frame-ending beat (1 cycle in SCAN-to-CLOSE, 1 cycle to load).
- **Latency with averaging:** one cycle later (3 edges).
- **Output handshake:** outputs are stable while `out_valid=1` and `out_ready=0`, unless overwritten as above. `out_valid` falls on the edge where `out_ready=1` and no load occurs.
- **Throughput:** one beat per cycle, sustained.

## Configuration
- **`SPECTRUM_PEAK_AVG_EN` defined:**
  - A per-bin store of `N_BINS` x 8 bits is used, with a synchronous read in the beat cycle and a write one cycle later.
  - Averaged value: `avg = old + ((mag - old) >>> 2)`, computed in a 9-bit signed intermediate and truncated to 8 bits.
  - In the first frame after reset, `avg = mag`.
  - The peak search and `peak_mag` use `avg`.
  - A read of a bin written in the previous cycle bypasses the store and uses the fresh value.
- **`SPECTRUM_PEAK_AVG_EN` undefined:** the raw `in_log_mag` feeds the search. No store is built, and latency is 2.

## Structure
- **Shared package `spectrum_pkg`:**
  - `LOG_MAG_W = 8`.
  - The state enum (SCAN, CLOSE).
  - The averaging shift constant `AVG_SHIFT = 2`.
- **Sub-module `spectrum_avg_ram`:** dual-port synchronous store with the read-during-write bypass. Instantiated only under `SPECTRUM_PEAK_AVG_EN`.

## Test plan
- **Single peak:** 512 beats of 5, except bin 100 = 200, with `in_last` on bin 511.
  - Expect `peak_bin=100`, `peak_mag=200`, `peak_found=1`, `len_err=0`.
- **Tie and threshold:**
  - Bins 7 and 300 both 90, all others 0: expect `peak_bin=7`.
  - All bins 10: expect `peak_found=0`, `peak_bin=0`.
- **Length errors:**
  - `in_last` at bin 255: expect `len_err=1` and a result from 256 bins.
  - No `in_last` for 600 beats: expect a forced close after beat 511, a second frame starting at beat 512, and `len_err=1`.
- **Backpressure:** hold `out_ready=0` across two frames.
  - Expect the second frame's result, `overrun=1`, `out_valid` held.
  - `err_clr` then clears both sticky flags.
- **Reset:** pulse `resetn` low mid-frame at bin 200.
  - Expect all outputs at 0 immediately (asynchronous).
  - The next full frame reports correctly.
- **Averaging (AVG_EN):**
  - Frame 1: bin 50 = 200. Expect `peak_mag=200`.
  - Frame 2: bin 50 = 0, bin 60 = 100. Expect the average at bin 50 to be 150, so `peak_bin=50`, `peak_mag=150`.
